// File: rtl/cam_frame_capture.sv
// cam_frame_capture: oversamples the camera bus on i_Clk, crops and decimates a luma window,
// and writes one WIDTH x HEIGHT grayscale frame into the frame RAM write port.
// Optional build macro: CAM_TEST_PATTERN_EN replaces the camera byte with {out_row[3:0], out_col[3:0]}.
module cam_frame_capture #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned HEIGHT    = 96,
  parameter int unsigned COL_START = 224,
  parameter int unsigned ROW_START = 144,
  parameter int unsigned DECIM     = 2,
  parameter int unsigned Y_PHASE   = 0
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_PLK,
  input  logic        i_VS,
  input  logic        i_HS,
  input  logic [7:0]  i_D,
  input  logic        i_Start,
  output logic        o_Wr_En,
  output logic [14:0] o_Wr_Addr,
  output logic [7:0]  o_Wr_Data,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Frame_Err
);

  localparam int unsigned AW      = 15;
  localparam int unsigned CW      = 10;
  localparam int unsigned RW      = 10;
  localparam int unsigned DW      = 2;
  localparam int unsigned TOTAL   = WIDTH * HEIGHT;
  localparam int unsigned COL_END = COL_START + WIDTH * DECIM;
  localparam int unsigned ROW_END = ROW_START + HEIGHT * DECIM;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Synchronizer chains: bit0 = first flop, bit1 = synced level, bit2 = previous synced level.
  logic [2:0]    plk_s_q, vs_s_q, hs_s_q;
  logic [7:0]    d_s1_q, d_s2_q;

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          phase_q, phase_d;
  logic [DW-1:0] rdec_q, rdec_d, cdec_q, cdec_d;
  logic [AW-1:0] addr_q, addr_d;

  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

`ifdef CAM_TEST_PATTERN_EN
  logic [AW-1:0] ocol_q, ocol_d, orow_q, orow_d;
`endif

  logic plk_rise_c, vs_rise_c, vs_fall_c, hs_rise_c, hs_fall_c, hs_lvl_c;
  logic row_in_c, col_in_c, keep_c;

  assign plk_rise_c = plk_s_q[1] & ~plk_s_q[2];
  assign vs_rise_c  = vs_s_q[1]  & ~vs_s_q[2];
  assign vs_fall_c  = ~vs_s_q[1] &  vs_s_q[2];
  assign hs_rise_c  = hs_s_q[1]  & ~hs_s_q[2];
  assign hs_fall_c  = ~hs_s_q[1] &  hs_s_q[2];
  assign hs_lvl_c   = hs_s_q[1];

  assign row_in_c = (row_q >= RW'(ROW_START)) && (row_q < RW'(ROW_END));
  assign col_in_c = (col_q >= CW'(COL_START)) && (col_q < CW'(COL_END));

  // Input synchronizers; data shares the PLK depth so it is stable when the rise is seen.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      plk_s_q <= '0;
      vs_s_q  <= '0;
      hs_s_q  <= '0;
      d_s1_q  <= '0;
      d_s2_q  <= '0;
    end else begin
      plk_s_q <= {plk_s_q[1:0], i_PLK};
      vs_s_q  <= {vs_s_q[1:0], i_VS};
      hs_s_q  <= {hs_s_q[1:0], i_HS};
      d_s1_q  <= i_D;
      d_s2_q  <= d_s1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state: arm on start, capture from VS fall, finish on VS rise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_Start)   state_d = S_ARM;
      S_ARM:     if (vs_fall_c) state_d = S_CAPTURE;
      S_CAPTURE: if (vs_rise_c) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values: pixel counting, window/decimation filter, RAM write, status.
  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    phase_d   = phase_q;
    rdec_d    = rdec_q;
    cdec_d    = cdec_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_d != S_IDLE);
    keep_c    = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
    ocol_d    = ocol_q;
    orow_d    = orow_q;
`endif
    case (state_q)
      S_ARM: begin
        if (vs_fall_c) begin
          row_d   = '0;
          col_d   = '0;
          phase_d = 1'b0;
          rdec_d  = '0;
          cdec_d  = '0;
          addr_d  = '0;
`ifdef CAM_TEST_PATTERN_EN
          ocol_d  = '0;
          orow_d  = '0;
`endif
        end
      end
      S_CAPTURE: begin
        if (hs_rise_c) begin
          phase_d = 1'b0;
          col_d   = '0;
          cdec_d  = '0;
        end else if (plk_rise_c && hs_lvl_c) begin
          if (phase_q == 1'(Y_PHASE)) begin
            keep_c = row_in_c && col_in_c && (rdec_q == '0) && (cdec_q == '0) &&
                     (addr_q < AW'(TOTAL));
          end
          if (keep_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            addr_d    = addr_q + AW'(1);
`ifdef CAM_TEST_PATTERN_EN
            wr_data_d = {orow_q[3:0], ocol_q[3:0]};
            if (ocol_q == AW'(WIDTH - 1)) begin
              ocol_d = '0;
              orow_d = orow_q + AW'(1);
            end else begin
              ocol_d = ocol_q + AW'(1);
            end
`else
            wr_data_d = d_s2_q;
`endif
          end
          phase_d = ~phase_q;
          if (phase_q) begin
            if (col_q != '1) col_d = col_q + CW'(1);
            if (col_q >= CW'(COL_START))
              cdec_d = (cdec_q == DW'(DECIM - 1)) ? '0 : cdec_q + DW'(1);
          end
        end
        if (hs_fall_c) begin
          if (row_q != '1) row_d = row_q + RW'(1);
          if (row_q >= RW'(ROW_START))
            rdec_d = (rdec_q == DW'(DECIM - 1)) ? '0 : rdec_q + DW'(1);
        end
        // A write landing in the same cycle as VS rise is counted toward completion.
        if (vs_rise_c) begin
          if (addr_d == AW'(TOTAL)) done_d = 1'b1;
          else                      err_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      phase_q   <= 1'b0;
      rdec_q    <= '0;
      cdec_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CAM_TEST_PATTERN_EN
      ocol_q    <= '0;
      orow_q    <= '0;
`endif
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      phase_q   <= phase_d;
      rdec_q    <= rdec_d;
      cdec_q    <= cdec_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CAM_TEST_PATTERN_EN
      ocol_q    <= ocol_d;
      orow_q    <= orow_d;
`endif
    end
  end

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = done_q;
  assign o_Frame_Err  = err_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Bench for cam_frame_capture on a scaled window (6x4 output, 16x12 camera frame, DECIM 2).
module tb_cam_frame_capture;

  localparam int W     = 6;
  localparam int H     = 4;
  localparam int CS    = 3;
  localparam int RS    = 2;
  localparam int DEC   = 2;
  localparam int YPH   = 0;
  localparam int TOTAL = W * H;
  localparam int CAM_W = 16;
  localparam int CAM_H = 12;
  localparam int LAST_COL = CS + (W - 1) * DEC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_PLK = 1'b0;
  logic        i_VS = 1'b1;
  logic        i_HS = 1'b0;
  logic [7:0]  i_D = 8'h00;
  logic        i_Start = 1'b0;
  logic        o_Wr_En;
  logic [14:0] o_Wr_Addr;
  logic [7:0]  o_Wr_Data;
  logic        o_Busy;
  logic        o_Frame_Done;
  logic        o_Frame_Err;

  cam_frame_capture #(
    .WIDTH(W), .HEIGHT(H), .COL_START(CS), .ROW_START(RS), .DECIM(DEC), .Y_PHASE(YPH)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_PLK(i_PLK), .i_VS(i_VS), .i_HS(i_HS), .i_D(i_D),
    .i_Start(i_Start), .o_Wr_En(o_Wr_En), .o_Wr_Addr(o_Wr_Addr), .o_Wr_Data(o_Wr_Data),
    .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Frame_Err(o_Frame_Err)
  );

  always #4 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_wr = 0;
  int n_done = 0;
  int n_err = 0;
  int m_addr = 0;
  bit expect_en = 1'b0;
  logic [7:0]  first_data;
  logic [14:0] last_addr;
  logic [22:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) i_Start = 1'b1;
    @(negedge clk) i_Start = 1'b0;
  endtask

  // Reference model: predicts the stored byte for one camera byte.
  task automatic model_byte(input int r, input int c, input int b, input logic [7:0] d);
    logic [7:0] e;
    if (expect_en && b == YPH && r >= RS && r < RS + H * DEC && c >= CS && c < CS + W * DEC &&
        ((r - RS) % DEC) == 0 && ((c - CS) % DEC) == 0 && m_addr < TOTAL) begin
`ifdef CAM_TEST_PATTERN_EN
      e = {4'(m_addr / W), 4'(m_addr % W)};
`else
      e = d;
`endif
      exp_q.push_back({15'(m_addr), e});
      m_addr++;
    end
  endtask

  // Camera frame: Y = row^col on luma byte, inverted on chroma byte; PLK = clk/8.
  task automatic send_frame(input int rows, input bit vs_on_last);
    i_VS = 1'b1; idle(20);
    i_VS = 1'b0; idle(20);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < CAM_W; c++) begin
        for (int b = 0; b < 2; b++) begin
          i_HS = 1'b1;
          i_D  = (b == YPH) ? 8'(r ^ c) : 8'(~(r ^ c));
          idle(4);
          i_PLK = 1'b1;
          model_byte(r, c, b, i_D);
          if (vs_on_last && r == rows - 1 && c == LAST_COL && b == YPH) begin
            i_VS = 1'b1;
            idle(4);
            i_PLK = 1'b0;
            i_HS  = 1'b0;
            idle(20);
            return;
          end
          idle(4);
          i_PLK = 1'b0;
        end
      end
      i_HS = 1'b0;
      idle(16);
    end
    i_VS = 1'b1;
    idle(20);
  endtask

  // Monitor: pops the scoreboard on every write and checks status pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_Wr_En) begin
        n_wr++;
        if (o_Wr_Addr == 15'd0) first_data = o_Wr_Data;
        last_addr = o_Wr_Addr;
        if (exp_q.size() == 0) chk("unexpected_write", {9'd0, o_Wr_Addr, o_Wr_Data}, 32'hFFFF_FFFF);
        else chk("write_addr_data", {9'd0, o_Wr_Addr, o_Wr_Data}, {9'd0, exp_q.pop_front()});
      end
      if (o_Frame_Done) begin
        n_done++;
        chk("busy_at_done", 32'(o_Busy), 32'd0);
      end
      if (o_Frame_Err) begin
        n_err++;
        chk("busy_at_err", 32'(o_Busy), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic frame_checks(input string tag, input int wr0, input int dn0, input int er0,
                              input int wr_exp, input int dn_exp, input int er_exp);
    chk({tag, "_writes"}, 32'(n_wr - wr0), 32'(wr_exp));
    chk({tag, "_done"}, 32'(n_done - dn0), 32'(dn_exp));
    chk({tag, "_err"}, 32'(n_err - er0), 32'(er_exp));
    chk({tag, "_busy_after"}, 32'(o_Busy), 32'd0);
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int wr0, dn0, er0, k;
    logic [7:0] first_exp;
`ifdef CAM_TEST_PATTERN_EN
    first_exp = 8'h00;
`else
    first_exp = 8'h01;
`endif
    // Reset state
    #3;
    chk("rst_wr_en", 32'(o_Wr_En), 32'd0);
    chk("rst_addr_data", {9'd0, o_Wr_Addr, o_Wr_Data}, 32'd0);
    chk("rst_busy_done_err", {29'd0, o_Busy, o_Frame_Done, o_Frame_Err}, 32'd0);
    idle(4);
    rst_n = 1'b1;
    idle(4);

    // Full frame
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    first_data = 8'hEE;
    pulse_start();
    idle(1);
    chk("t1_busy_armed", 32'(o_Busy), 32'd1);
    m_addr = 0; expect_en = 1'b1;
    send_frame(CAM_H, 1'b0);
    idle(10);
    frame_checks("t1", wr0, dn0, er0, TOTAL, 1, 0);
    chk("t1_first_byte", 32'(first_data), 32'(first_exp));
    chk("t1_last_addr", 32'(last_addr), 32'(TOTAL - 1));

    // Armed mid-frame: nothing until the next frame start
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    expect_en = 1'b0;
    fork
      send_frame(CAM_H, 1'b0);
      begin idle(1500); pulse_start(); end
    join
    chk("t2_no_partial_writes", 32'(n_wr - wr0), 32'd0);
    chk("t2_still_armed", 32'(o_Busy), 32'd1);
    m_addr = 0; expect_en = 1'b1;
    send_frame(CAM_H, 1'b0);
    idle(10);
    frame_checks("t2", wr0, dn0, er0, TOTAL, 1, 0);

    // Short frame: 5 lines keep rows 2 and 4 only
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    m_addr = 0; expect_en = 1'b1;
    send_frame(5, 1'b0);
    idle(10);
    frame_checks("t3", wr0, dn0, er0, 2 * W, 0, 1);

    // Second start during capture is ignored
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    m_addr = 0; expect_en = 1'b1;
    fork
      send_frame(CAM_H, 1'b0);
      begin idle(1500); pulse_start(); idle(1); chk("t4_busy_on_restart", 32'(o_Busy), 32'd1); end
    join
    idle(10);
    frame_checks("t4", wr0, dn0, er0, TOTAL, 1, 0);

    // Reset mid-capture aborts silently
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    m_addr = 0; expect_en = 1'b1;
    fork
      send_frame(CAM_H, 1'b0);
      begin
        k = 0;
        while (k < 5000 && n_wr < wr0 + 10) begin @(negedge clk); k++; end
        chk("t5_reached_mid_frame", 32'(n_wr - wr0 >= 10), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        expect_en = 1'b0;
        #1;
        chk("t5_rst_outputs", {23'd0, o_Wr_En, o_Busy, o_Frame_Done, o_Frame_Err, 5'd0}, 32'd0);
        chk("t5_rst_addr_data", {9'd0, o_Wr_Addr, o_Wr_Data}, 32'd0);
        exp_q.delete();
        idle(5);
        rst_n = 1'b1;
      end
    join
    idle(10);
    chk("t5_no_done", 32'(n_done - dn0), 32'd0);
    chk("t5_no_err", 32'(n_err - er0), 32'd0);
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    m_addr = 0; expect_en = 1'b1;
    send_frame(CAM_H, 1'b0);
    idle(10);
    frame_checks("t5_restart", wr0, dn0, er0, TOTAL, 1, 0);

    // Last kept byte coincides with VS rise: still a complete frame
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    pulse_start();
    m_addr = 0; expect_en = 1'b1;
    send_frame(RS + (H - 1) * DEC + 1, 1'b1);
    idle(10);
    frame_checks("t7", wr0, dn0, er0, TOTAL, 1, 0);
    chk("t7_last_addr", 32'(last_addr), 32'(TOTAL - 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
